// File: rtl/accum_pkg.sv
// Shared definitions for the packetizer and accumulator: FSM encoding,
// full-keep constant and the default data-packet length.
package accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  localparam int                    ACC_KEEP_W      = 2;
  localparam logic [ACC_KEEP_W-1:0] KEEP_FULL       = 2'b11;
  localparam int unsigned           ACC_DEFAULT_LEN = 32'd200704;

  // A zero job length selects the build-time default length.
  function automatic logic [31:0] resolve_len(input logic [31:0] len,
                                              input logic [31:0] dflt);
    return (len == 32'd0) ? dflt : len;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry registered AXI-Stream stage; the held word stays stable until
// the downstream handshake and a new word can load in that same cycle.
module axis_reg_slice #(
  parameter int DATA_W = 32,
  parameter int KEEP_W = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [DATA_W-1:0] in_tdata,
  input  logic [KEEP_W-1:0] in_tkeep,
  input  logic              in_tlast,
  input  logic              in_tvalid,
  output logic              in_tready,
  output logic [DATA_W-1:0] out_tdata,
  output logic [KEEP_W-1:0] out_tkeep,
  output logic              out_tlast,
  output logic              out_tvalid,
  input  logic              out_tready
);

  assign in_tready = !out_tvalid || out_tready;

  // Output register: load on input handshake, empty on output handshake.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_tdata  <= {DATA_W{1'b0}};
      out_tkeep  <= {KEEP_W{1'b0}};
      out_tlast  <= 1'b0;
      out_tvalid <= 1'b0;
    end else if (in_tvalid && in_tready) begin
      out_tdata  <= in_tdata;
      out_tkeep  <= in_tkeep;
      out_tlast  <= in_tlast;
      out_tvalid <= 1'b1;
    end else if (out_tvalid && out_tready) begin
      out_tvalid <= 1'b0;
    end else begin
      out_tvalid <= out_tvalid;
    end
  end

endmodule

// File: rtl/accum_packetizer.sv
// Frames a raw AXI-Stream into a one-word channel header followed by a
// fixed-length data packet for the accumulator.
import accum_pkg::*;

module accum_packetizer #(
  parameter int unsigned DEFAULT_LEN = ACC_DEFAULT_LEN,
  parameter int          KEEP_W      = ACC_KEEP_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic [31:0]       cfg_channel,
  input  logic [31:0]       cfg_len,
  output logic              busy,
  output logic              done,
  input  logic [31:0]       S_AXIS_TDATA,
  input  logic [KEEP_W-1:0] S_AXIS_TKEEP,
  input  logic              S_AXIS_TLAST,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  output logic [31:0]       M_AXIS_TDATA,
  output logic [KEEP_W-1:0] M_AXIS_TKEEP,
  output logic              M_AXIS_TLAST,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY
);

  localparam logic [KEEP_W-1:0] KEEP_ONES_C = {KEEP_W{1'b1}};

  state_t      state_r, state_next_s;
  logic [31:0] chan_r, len_r, cnt_r;
  logic        busy_r, done_r;
  logic        start_ok_s, room_s, keep_ok_s, fwd_s, last_fire_s;
  logic        slc_valid_s, slc_ready_s, slc_last_s;
  logic [31:0] slc_data_s;
  logic        unused_s;

  // Input TLAST plays no part in framing.
  assign unused_s = S_AXIS_TLAST;

  assign start_ok_s    = (state_r == ST_IDLE) && cfg_start && !done_r;
  assign room_s        = (cnt_r != len_r);
  assign keep_ok_s     = (S_AXIS_TKEEP == KEEP_ONES_C);
  assign S_AXIS_TREADY = !ARESET && (state_r == ST_DATA) && room_s && slc_ready_s;
  assign fwd_s         = S_AXIS_TVALID && S_AXIS_TREADY && keep_ok_s;
  assign last_fire_s   = (state_r == ST_DATA) && M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
  assign busy          = busy_r;
  assign done          = done_r;

  // Output-stage source: header word in HDR, kept input words in DATA.
  always_comb begin
    slc_valid_s = 1'b0;
    slc_data_s  = 32'd0;
    slc_last_s  = 1'b0;
    case (state_r)
      ST_HDR: begin
        slc_valid_s = !M_AXIS_TVALID;
        slc_data_s  = chan_r;
        slc_last_s  = 1'b1;
      end
      ST_DATA: begin
        slc_valid_s = S_AXIS_TVALID && keep_ok_s && room_s;
        slc_data_s  = S_AXIS_TDATA;
        slc_last_s  = ((cnt_r + 32'd1) == len_r);
      end
      default: begin
        slc_valid_s = 1'b0;
      end
    endcase
  end

  // Next-state logic; DATA only exits once the final word has left.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) state_next_s = ST_HDR;
        else            state_next_s = ST_IDLE;
      end
      ST_HDR: begin
        if (M_AXIS_TVALID && M_AXIS_TREADY) state_next_s = ST_DATA;
        else                                state_next_s = ST_HDR;
      end
      ST_DATA: begin
        if (last_fire_s) state_next_s = ST_IDLE;
        else             state_next_s = ST_DATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, job configuration, word counter and status flags.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r <= ST_IDLE;
      chan_r  <= 32'd0;
      len_r   <= 32'd0;
      cnt_r   <= 32'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= last_fire_s;
      if (start_ok_s) begin
        chan_r <= cfg_channel;
        len_r  <= resolve_len(cfg_len, 32'(DEFAULT_LEN));
        cnt_r  <= 32'd0;
      end else if (fwd_s) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  axis_reg_slice #(
    .DATA_W (32),
    .KEEP_W (KEEP_W)
  ) u_slice (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .in_tdata   (slc_data_s),
    .in_tkeep   (KEEP_ONES_C),
    .in_tlast   (slc_last_s),
    .in_tvalid  (slc_valid_s),
    .in_tready  (slc_ready_s),
    .out_tdata  (M_AXIS_TDATA),
    .out_tkeep  (M_AXIS_TKEEP),
    .out_tlast  (M_AXIS_TLAST),
    .out_tvalid (M_AXIS_TVALID),
    .out_tready (M_AXIS_TREADY)
  );

endmodule

// File: tb/tb_accum_packetizer.sv
// Bench for accum_packetizer: a queue-based packet model is compared against
// every output handshake, with directed jobs and hand-computed pins.
module tb_accum_packetizer;

  localparam int          KW         = 2;
  localparam int unsigned TB_DEF_LEN = 6;

  logic          ACLK, ARESET;
  logic          cfg_start;
  logic [31:0]   cfg_channel, cfg_len;
  logic          busy, done;
  logic [31:0]   S_AXIS_TDATA;
  logic [KW-1:0] S_AXIS_TKEEP;
  logic          S_AXIS_TLAST, S_AXIS_TVALID, S_AXIS_TREADY;
  logic [31:0]   M_AXIS_TDATA;
  logic [KW-1:0] M_AXIS_TKEEP;
  logic          M_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY;

  typedef struct packed {logic [31:0] data; logic [1:0] keep; logic last;} in_t;
  typedef struct packed {logic [31:0] data; logic last; logic fin; logic hdr;} out_t;

  in_t  src_q[$];
  out_t exp_q[$];
  int   checks = 0, errors = 0;
  int   done_cnt = 0, data_hs_cnt = 0, rdy_mode = 0, rdy_phase = 0;
  logic s_fire_pend = 1'b0, exp_done = 1'b0, prev_stall = 1'b0, mon_en = 1'b0;
  logic prev_last = 1'b0;
  logic [31:0] prev_data = 32'd0;
  out_t mon_e;

  accum_packetizer #(.DEFAULT_LEN(TB_DEF_LEN), .KEEP_W(KW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cfg_start(cfg_start), .cfg_channel(cfg_channel),
    .cfg_len(cfg_len), .busy(busy), .done(done),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TKEEP(S_AXIS_TKEEP), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TKEEP(M_AXIS_TKEEP), .M_AXIS_TLAST(M_AXIS_TLAST),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_in(input logic [31:0] d, input logic [1:0] k, input logic l);
    in_t w;
    w.data = d; w.keep = k; w.last = l;
    src_q.push_back(w);
  endtask

  // Model: header word, then the first n full-keep input words, TLAST on word n.
  task automatic queue_job(input logic [31:0] ch, input logic [31:0] len_cfg);
    int unsigned n;
    int unsigned got;
    out_t o;
    n = (len_cfg == 32'd0) ? TB_DEF_LEN : len_cfg;
    got = 0;
    o.data = ch; o.last = 1'b1; o.fin = 1'b0; o.hdr = 1'b1;
    exp_q.push_back(o);
    foreach (src_q[i]) begin
      if (got < n && src_q[i].keep == 2'b11) begin
        got++;
        o.data = src_q[i].data; o.last = (got == n); o.fin = (got == n); o.hdr = 1'b0;
        exp_q.push_back(o);
      end
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #2;
  endtask

  task automatic start_job(input logic [31:0] ch, input logic [31:0] len);
    tick();
    cfg_start = 1'b1; cfg_channel = ch; cfg_len = len;
    tick();
    cfg_start = 1'b0;
    @(negedge ACLK);
    chk("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    int start;
    start = done_cnt;
    for (int i = 0; i < 2000 && done_cnt == start; i++) @(posedge ACLK);
    if (done_cnt == start) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done not seen, expected within 2000 cycles", name);
    end
    chk({name, "_all_out"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Stimulus source and downstream ready pattern, updated just after each edge.
  initial begin
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = 32'd0; S_AXIS_TKEEP = 2'b00; S_AXIS_TLAST = 1'b0;
    M_AXIS_TREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      if (s_fire_pend && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        S_AXIS_TVALID = 1'b1; S_AXIS_TDATA = src_q[0].data;
        S_AXIS_TKEEP = src_q[0].keep; S_AXIS_TLAST = src_q[0].last;
      end else begin
        S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = 32'd0; S_AXIS_TKEEP = 2'b00; S_AXIS_TLAST = 1'b0;
      end
      if (rdy_mode == 1) begin
        M_AXIS_TREADY = (rdy_phase == 0);
        rdy_phase = (rdy_phase + 1) % 3;
      end else begin
        M_AXIS_TREADY = 1'b1;
        rdy_phase = 0;
      end
    end
  end

  // Compare process: sampled mid-cycle, a handshake happens at the next edge.
  initial begin
    logic m_f;
    forever begin
      @(negedge ACLK);
      m_f = M_AXIS_TVALID && M_AXIS_TREADY && !ARESET;
      s_fire_pend = S_AXIS_TVALID && S_AXIS_TREADY && !ARESET;
      if (done) done_cnt++;
      if (mon_en) begin
        chk("done", 32'(done), 32'(exp_done));
        if (prev_stall) begin
          chk("stall_valid", 32'(M_AXIS_TVALID), 32'd1);
          chk("stall_data", M_AXIS_TDATA, prev_data);
          chk("stall_last", 32'(M_AXIS_TLAST), 32'(prev_last));
        end
      end
      exp_done = 1'b0;
      if (mon_en && m_f) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got data %0h, expected no output", M_AXIS_TDATA);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", M_AXIS_TDATA, mon_e.data);
          chk("out_last", 32'(M_AXIS_TLAST), 32'(mon_e.last));
          chk("out_keep", 32'(M_AXIS_TKEEP), 32'd3);
          exp_done = mon_e.fin;
          if (!mon_e.hdr) data_hs_cnt++;
        end
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY && !ARESET;
      prev_data  = M_AXIS_TDATA;
      prev_last  = M_AXIS_TLAST;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string name);
    chk({name, "_mvalid"}, 32'(M_AXIS_TVALID), 32'd0);
    chk({name, "_mlast"},  32'(M_AXIS_TLAST),  32'd0);
    chk({name, "_mdata"},  M_AXIS_TDATA,       32'd0);
    chk({name, "_mkeep"},  32'(M_AXIS_TKEEP),  32'd0);
    chk({name, "_sready"}, 32'(S_AXIS_TREADY), 32'd0);
    chk({name, "_busy"},   32'(busy),          32'd0);
    chk({name, "_done"},   32'(done),          32'd0);
  endtask

  initial begin
    int target;
    ARESET = 1'b1; cfg_start = 1'b0; cfg_channel = 32'd0; cfg_len = 32'd0;
    @(posedge ACLK);
    @(negedge ACLK);
    check_all_zero("rst_during");
    tick();
    tick();
    ARESET = 1'b0;
    @(negedge ACLK);
    check_all_zero("rst_after");
    mon_en = 1'b1;

    // Job 1: header 5, floats 1.0..4.0; cfg_start in the done cycle is ignored.
    push_in(32'h3F800000, 2'b11, 1'b0);
    push_in(32'h40000000, 2'b11, 1'b0);
    push_in(32'h40400000, 2'b11, 1'b0);
    push_in(32'h40800000, 2'b11, 1'b1);
    exp_q.push_back('{data: 32'd5,        last: 1'b1, fin: 1'b0, hdr: 1'b1});
    exp_q.push_back('{data: 32'h3F800000, last: 1'b0, fin: 1'b0, hdr: 1'b0});
    exp_q.push_back('{data: 32'h40000000, last: 1'b0, fin: 1'b0, hdr: 1'b0});
    exp_q.push_back('{data: 32'h40400000, last: 1'b0, fin: 1'b0, hdr: 1'b0});
    exp_q.push_back('{data: 32'h40800000, last: 1'b1, fin: 1'b1, hdr: 1'b0});
    start_job(32'd5, 32'd4);
    for (int i = 0; i < 200; i++) begin
      if (M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TDATA == 32'h40800000) break;
      @(negedge ACLK);
    end
    tick();
    cfg_start = 1'b1; cfg_channel = 32'd99; cfg_len = 32'd1;
    @(negedge ACLK);
    chk("t1_done_pulse", 32'(done), 32'd1);
    tick();
    cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t1_idle_busy", 32'(busy), 32'd0);
    end
    chk("t1_all_out", 32'(exp_q.size()), 32'd0);

    // Job 2: stalled downstream, ready pattern 1,0,0.
    rdy_mode = 1;
    push_in(32'hA1, 2'b11, 1'b0);
    push_in(32'hA2, 2'b11, 1'b0);
    push_in(32'hA3, 2'b11, 1'b1);
    queue_job(32'd7, 32'd3);
    start_job(32'd7, 32'd3);
    wait_done("t2");
    chk("t2_inputs_used", 32'(src_q.size()), 32'd0);
    rdy_mode = 0;

    // Job 3: partial-keep words dropped; pin the model output by hand.
    push_in(32'h10, 2'b01, 1'b0);
    push_in(32'h11, 2'b11, 1'b0);
    push_in(32'h12, 2'b11, 1'b0);
    push_in(32'h13, 2'b00, 1'b0);
    push_in(32'h14, 2'b11, 1'b1);
    queue_job(32'd9, 32'd3);
    chk("model_size", 32'(exp_q.size()), 32'd4);
    chk("model_w1", exp_q[1].data, 32'h11);
    chk("model_w2", exp_q[2].data, 32'h12);
    chk("model_w3", exp_q[3].data, 32'h14);
    chk("model_w3_last", 32'(exp_q[3].last), 32'd1);
    start_job(32'd9, 32'd3);
    wait_done("t3");
    chk("t3_inputs_used", 32'(src_q.size()), 32'd0);

    // Job 4: early input TLAST, and a second cfg_start mid-job.
    push_in(32'h21, 2'b11, 1'b0);
    push_in(32'h22, 2'b11, 1'b1);
    push_in(32'h23, 2'b11, 1'b0);
    push_in(32'h24, 2'b11, 1'b0);
    queue_job(32'h44, 32'd4);
    start_job(32'h44, 32'd4);
    tick();
    cfg_start = 1'b1; cfg_channel = 32'hEE; cfg_len = 32'd1;
    tick();
    cfg_start = 1'b0;
    wait_done("t4");
    for (int i = 0; i < 5; i++) tick();
    @(negedge ACLK);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_valid", 32'(M_AXIS_TVALID), 32'd0);

    // Job 5: reset after data word 2, then a clean short job.
    for (int i = 0; i < 8; i++) push_in(32'h50 + 32'(i), 2'b11, 1'b0);
    queue_job(32'h55, 32'd8);
    target = data_hs_cnt + 2;
    start_job(32'h55, 32'd8);
    for (int i = 0; i < 200 && data_hs_cnt < target; i++) @(negedge ACLK);
    chk("t5_two_words", 32'(data_hs_cnt), 32'(target));
    mon_en = 1'b0;
    tick();
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    src_q.delete();
    exp_q.delete();
    @(negedge ACLK);
    check_all_zero("t5_rst");
    mon_en = 1'b1;
    tick();
    push_in(32'h61, 2'b11, 1'b0);
    push_in(32'h62, 2'b11, 1'b0);
    queue_job(32'h66, 32'd2);
    start_job(32'h66, 32'd2);
    wait_done("t5b");

    // Job 6: cfg_len 0 selects the default length; extra input stays unread.
    for (int i = 0; i < 8; i++) push_in(32'h70 + 32'(i), 2'b11, 1'b0);
    queue_job(32'h77, 32'd0);
    chk("model_def_len", 32'(exp_q.size()), 32'(TB_DEF_LEN + 1));
    start_job(32'h77, 32'd0);
    wait_done("t6");
    for (int i = 0; i < 4; i++) tick();
    chk("t6_leftover", 32'(src_q.size()), 32'd2);
    src_q.delete();
    for (int i = 0; i < 3; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
